// File: rtl/sign_mag_accum_ctrl.sv
// Sequencer that sums a run of sign-magnitude ROM words through an external adder.
// It uses a saturating accumulator with a sticky per-run overflow flag.
module sign_mag_accum_ctrl #(
  parameter int N      = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      result,
  output logic              overflow,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [N-1:0]      rom_data,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  input  logic [N-1:0]      add_sum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ACC   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [N-1:0] MAG_MAX = {1'b0, {(N-1){1'b1}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [N-1:0]      result_q, result_d;
  logic              ovf_q, ovf_d;

  logic              acc_neg;
  logic              data_neg;
  logic              sat;
  logic [N-1:0]      mag_sum;
  logic [N-1:0]      sum_norm;
  logic [N-1:0]      next_acc;

  // The address is presented combinationally in FETCH so the registered ROM
  // delivers the word during ACC; outside FETCH the last address is held.
  assign rom_addr = (state_q == FETCH) ? (base_q + idx_q) : addr_q;
  assign addr_d   = rom_addr;
  assign add_a    = acc_q;
  assign add_b    = (state_q == ACC) ? rom_data : '0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = ovf_q;

  // A -0 word counts as positive; acc never holds -0, so its sign bit is exact.
  always_comb begin
    acc_neg  = acc_q[N-1];
    data_neg = rom_data[N-1] & (|rom_data[N-2:0]);
    mag_sum  = {1'b0, acc_q[N-2:0]} + {1'b0, rom_data[N-2:0]};
    sat      = (acc_neg == data_neg) && (mag_sum > MAG_MAX);
    sum_norm = (add_sum[N-2:0] == '0) ? '0 : add_sum;
    next_acc = sat ? {acc_neg, {(N-1){1'b1}}} : sum_norm;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = len;
          idx_d  = '0;
          acc_d  = '0;
          ovf_d  = 1'b0;
          if (len != '0) begin
            state_d = FETCH;
          end else begin
            state_d  = DONE;
            result_d = '0;
          end
        end
      end
      FETCH: begin
        state_d = ACC;
      end
      ACC: begin
        acc_d = next_acc;
        idx_d = idx_q + ADDR_W'(1);
        if (sat) begin
          ovf_d = 1'b1;
        end
        // Result is captured on entry to DONE so it is valid with the pulse.
        if (idx_q == len_q - ADDR_W'(1)) begin
          state_d  = DONE;
          result_d = next_acc;
        end else begin
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sign_mag_accum_ctrl.sv
// Bench for sign_mag_accum_ctrl: models sync_rom and sign_mag_add around the DUT.
// Each accepted run's expected result is scored against an integer reference.
module tb_sign_mag_accum_ctrl;

  typedef struct {
    logic [3:0] res;
    logic       ov;
    int         doneCyc;
  } expT;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] baseAddr;
  logic [7:0] lenIn;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       overflow;
  logic [7:0] romAddr;
  logic [3:0] romData;
  logic [3:0] addA;
  logic [3:0] addB;
  logic [3:0] addSum;

  logic [3:0] rom [256];
  expT        sbQ [$];
  expT        monE;
  expT        wrapE;
  int         cyc;
  int         checks;
  int         errors;

  sign_mag_accum_ctrl #(.N(4), .ADDR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(baseAddr),
    .len      (lenIn),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .rom_addr (romAddr),
    .rom_data (romData),
    .add_a    (addA),
    .add_b    (addB),
    .add_sum  (addSum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Environment models: registered ROM and a combinational sign-magnitude adder.
  always @(posedge clk) romData <= rom[romAddr];

  function automatic int smValue(input logic [3:0] w);
    int v;
    v = int'(w[2:0]);
    if (w[3]) v = -v;
    return v;
  endfunction

  function automatic logic [3:0] smAdd(input logic [3:0] a, input logic [3:0] b);
    int s;
    logic [2:0] mag;
    s = smValue(a) + smValue(b);
    mag = (s < 0) ? 3'(-s) : 3'(s);
    return {(s < 0) && (mag != 3'd0), mag};
  endfunction

  always_comb addSum = smAdd(addA, addB);

  // Reference: plain signed sum clamped to +/-7 after every word.
  task automatic refRun(input logic [7:0] b, input logic [7:0] l,
                        output logic [3:0] res, output logic ov);
    int sum;
    logic [3:0] w;
    sum = 0;
    ov = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      w = rom[8'(int'(b) + i)];
      sum += smValue(w);
      if (sum > 7) begin
        sum = 7;
        ov = 1'b1;
      end else if (sum < -7) begin
        sum = -7;
        ov = 1'b1;
      end
    end
    res = (sum < 0) ? {1'b1, 3'(-sum)} : {1'b0, 3'(sum)};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse retires the oldest expected run.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got done=1 required no pending run");
      end else begin
        monE = sbQ.pop_front();
        checkOutput("result", 32'(result), 32'(monE.res));
        checkOutput("overflow", 32'(overflow), 32'(monE.ov));
        checkOutput("doneCycle", cyc, monE.doneCyc);
      end
    end
  end

  task automatic waitDone(input int budget, input string tag);
    int k;
    k = 0;
    while (sbQ.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done within %0d cycles required done", tag, budget);
      sbQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] l,
                               input bit pokeBusy, input bit pokeDone);
    expT e;
    logic [3:0] prevRes;
    refRun(b, l, e.res, e.ov);
    @(negedge clk);
    #1;
    e.doneCyc = cyc + 1 + 2 * int'(l);
    sbQ.push_back(e);
    start = 1'b1;
    baseAddr = b;
    lenIn = l;
    @(negedge clk);
    #1;
    start = 1'b0;
    baseAddr = 8'($urandom);
    lenIn = 8'($urandom);
    checkOutput("busyAfterStart", 32'(busy), 1);
    if (pokeBusy && l != 8'd0) begin
      prevRes = result;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      checkOutput("resultHeldWhileBusy", 32'(result), 32'(prevRes));
    end
    waitDone(2 * int'(l) + 6, "run");
    if (pokeDone) start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    checkOutput("idleAfterDone", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    baseAddr = 8'd0;
    lenIn = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 4'd0;
    #2;
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstResult", 32'(result), 0);
    checkOutput("rstOverflow", 32'(overflow), 0);
    checkOutput("rstRomAddr", 32'(romAddr), 0);
    checkOutput("rstAddA", 32'(addA), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    rom[8'h10] = 4'b0011; rom[8'h11] = 4'b0010; rom[8'h12] = 4'b1001;
    rom[8'h20] = 4'b0101; rom[8'h21] = 4'b0100;
    rom[8'h30] = 4'b1011; rom[8'h31] = 4'b1010;
    rom[8'h40] = 4'b0011; rom[8'h41] = 4'b1011;
    rom[8'h50] = 4'b1010; rom[8'h51] = 4'b1000;
    rom[8'h60] = 4'b1111; rom[8'h61] = 4'b1111;
    rom[8'hFF] = 4'b0010; rom[8'h00] = 4'b0001;

    applyStimulus(8'h10, 8'd3, 1'b0, 1'b0);
    applyStimulus(8'h20, 8'd2, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'd3, 1'b1, 1'b0);
    applyStimulus(8'h20, 8'd2, 1'b0, 1'b1);

    // Abort a run in ACC; a non-zero result from the previous run must clear.
    @(negedge clk);
    #1;
    start = 1'b1;
    baseAddr = 8'h10;
    lenIn = 8'd3;
    @(negedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(busy), 0);
    checkOutput("midResetResult", 32'(result), 0);
    checkOutput("midResetOverflow", 32'(overflow), 0);
    checkOutput("midResetRomAddr", 32'(romAddr), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(8'h10, 8'd3, 1'b0, 1'b0);

    applyStimulus(8'h30, 8'd2, 1'b0, 1'b0);
    applyStimulus(8'h40, 8'd2, 1'b0, 1'b0);
    applyStimulus(8'h50, 8'd2, 1'b0, 1'b0);
    applyStimulus(8'h60, 8'd2, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'd0, 1'b0, 1'b0);

    // Address wrap with per-cycle view of address and operand B.
    refRun(8'hFF, 8'd2, wrapE.res, wrapE.ov);
    @(negedge clk);
    #1;
    wrapE.doneCyc = cyc + 1 + 4;
    sbQ.push_back(wrapE);
    start = 1'b1;
    baseAddr = 8'hFF;
    lenIn = 8'd2;
    @(negedge clk);
    #1;
    start = 1'b0;
    checkOutput("wrapAddrFirst", 32'(romAddr), 32'h0FF);
    checkOutput("fetchAddB", 32'(addB), 0);
    @(negedge clk);
    #1;
    checkOutput("accHoldAddr", 32'(romAddr), 32'h0FF);
    checkOutput("accAddB", 32'(addB), 32'(rom[8'hFF]));
    checkOutput("accAddA", 32'(addA), 0);
    @(negedge clk);
    #1;
    checkOutput("wrapAddrSecond", 32'(romAddr), 32'h000);
    waitDone(10, "wrap");

    for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(0, 15));
    repeat (40) begin
      applyStimulus(8'($urandom), 8'($urandom_range(0, 8)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
